// File: rtl/burst_migrator_if.sv
// Handshake and data signals between the burst migrator and its read/write FIFOs and controller.
// The master side is the migrator; the slave side is its environment.
interface burst_migrator_if #(
  parameter int unsigned DATA_W         = 512,
  parameter int unsigned FIFO_PTR_WIDTH = 6,
  parameter int unsigned MAX_LINES      = 64,
  parameter int unsigned SIZE_W         = 14
);
  localparam int unsigned CNT_W = $clog2(MAX_LINES + 1);

  logic                      migrate_start;
  logic                      abort_i;
  logic [SIZE_W-1:0]         comp_size;
  logic [FIFO_PTR_WIDTH-1:0] rdfifo_rdptr;
  logic                      ld_rdfifo_rdptr;
  logic                      rdfifo_empty;
  logic                      rd_req;
  logic [DATA_W-1:0]         rd_data;
  logic [1:0]                rd_rresp;
  logic                      rd_valid;
  logic                      wrfifo_full;
  logic                      wr_req;
  logic [DATA_W-1:0]         wr_data;
  logic                      migrate_done;
  logic                      err_o;
  logic [CNT_W-1:0]          lines_done;

  modport master (
    input  migrate_start, abort_i, comp_size, rdfifo_empty, rd_data, rd_rresp, rd_valid,
           wrfifo_full,
    output rdfifo_rdptr, ld_rdfifo_rdptr, rd_req, wr_req, wr_data, migrate_done, err_o,
           lines_done
  );

  modport slave (
    output migrate_start, abort_i, comp_size, rdfifo_empty, rd_data, rd_rresp, rd_valid,
           wrfifo_full,
    input  rdfifo_rdptr, ld_rdfifo_rdptr, rd_req, wr_req, wr_data, migrate_done, err_o,
           lines_done
  );
endinterface

// File: rtl/burst_migrator.sv
// Moves a byte-sized region, one cacheline beat at a time, from a read FIFO to a write FIFO.
// One read outstanding at most; a non-OKAY response parks the block in ERROR until abort.
module burst_migrator #(
  parameter int unsigned DATA_W         = 512,
  parameter int unsigned FIFO_PTR_WIDTH = 6,
  parameter int unsigned MAX_LINES      = 64,
  parameter int unsigned SIZE_W         = 14
) (
  input logic             clk_i,
  input logic             rst_ni,
  burst_migrator_if.master bus
);
  localparam int unsigned CNT_W        = $clog2(MAX_LINES + 1);
  localparam int unsigned BytesPerLine = DATA_W / 8;
  localparam int unsigned ByteShift    = $clog2(BytesPerLine);
  localparam logic [SIZE_W:0] RoundUp     = (SIZE_W + 1)'(BytesPerLine - 1);
  localparam logic [SIZE_W:0] MaxLinesExt = (SIZE_W + 1)'(MAX_LINES);
  localparam logic [FIFO_PTR_WIDTH-1:0] ReloadPtr = '0;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StXfer  = 2'd1,
    StDone  = 2'd2,
    StError = 2'd3
  } state_e;

  state_e state_q, state_d;

  logic [CNT_W-1:0]  target_q, target_d;
  logic [CNT_W-1:0]  issued_q, issued_d;
  logic [CNT_W-1:0]  lines_done_q, lines_done_d;
  logic              outstanding_q, outstanding_d;
  logic              rd_req_q, rd_req_d;
  logic              wr_req_q, wr_req_d;
  logic [DATA_W-1:0] wr_data_q, wr_data_d;
  logic              ld_ptr_q, ld_ptr_d;

  logic [SIZE_W:0]   size_lines;
  logic [CNT_W-1:0]  start_target;
  logic              rd_accept, rd_ok, rd_bad, can_issue, xfer_last;

  // Round the byte count up to whole lines, then clamp to the line budget.
  assign size_lines   = ({1'b0, bus.comp_size} + RoundUp) >> ByteShift;
  assign start_target = (size_lines > MaxLinesExt) ? CNT_W'(MAX_LINES) : CNT_W'(size_lines);

  assign rd_accept = bus.rd_valid & outstanding_q;
  assign rd_ok     = rd_accept & (bus.rd_rresp == 2'b00);
  assign rd_bad    = rd_accept & (bus.rd_rresp != 2'b00);
  assign can_issue = ~bus.rdfifo_empty & ~bus.wrfifo_full & ~outstanding_q &
                     (issued_q < target_q);
  assign xfer_last = wr_req_q & (lines_done_q == target_q);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle: begin
        if (bus.migrate_start && !bus.abort_i) begin
          state_d = (start_target == '0) ? StDone : StXfer;
        end
      end
      StXfer: begin
        if (bus.abort_i) begin
          state_d = StIdle;
        end else if (rd_bad) begin
          state_d = StError;
        end else if (xfer_last) begin
          state_d = StDone;
        end
      end
      StDone: begin
        if (bus.abort_i || !bus.migrate_start) begin
          state_d = StIdle;
        end
      end
      StError: begin
        if (bus.abort_i) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    target_d      = target_q;
    issued_d      = issued_q;
    lines_done_d  = lines_done_q;
    outstanding_d = outstanding_q;
    rd_req_d      = 1'b0;
    wr_req_d      = 1'b0;
    wr_data_d     = '0;
    ld_ptr_d      = 1'b0;
    case (state_q)
      StIdle: begin
        outstanding_d = 1'b0;
        if (bus.migrate_start && !bus.abort_i) begin
          target_d     = start_target;
          issued_d     = '0;
          lines_done_d = '0;
        end
      end
      StXfer: begin
        if (bus.abort_i) begin
          // Drop the in-flight read and rewind the read FIFO.
          outstanding_d = 1'b0;
          ld_ptr_d      = 1'b1;
        end else if (rd_accept) begin
          outstanding_d = 1'b0;
          if (rd_ok && (lines_done_q != target_q)) begin
            wr_req_d     = 1'b1;
            wr_data_d    = bus.rd_data;
            lines_done_d = lines_done_q + 1'b1;
          end
        end else if (can_issue) begin
          rd_req_d      = 1'b1;
          outstanding_d = 1'b1;
          issued_d      = issued_q + 1'b1;
        end
      end
      StDone: begin
        outstanding_d = 1'b0;
        if (bus.abort_i) begin
          ld_ptr_d = 1'b1;
        end
      end
      StError: begin
        outstanding_d = 1'b0;
      end
      default: outstanding_d = 1'b0;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      target_q      <= '0;
      issued_q      <= '0;
      lines_done_q  <= '0;
      outstanding_q <= 1'b0;
      rd_req_q      <= 1'b0;
      wr_req_q      <= 1'b0;
      wr_data_q     <= '0;
      ld_ptr_q      <= 1'b0;
    end else begin
      target_q      <= target_d;
      issued_q      <= issued_d;
      lines_done_q  <= lines_done_d;
      outstanding_q <= outstanding_d;
      rd_req_q      <= rd_req_d;
      wr_req_q      <= wr_req_d;
      wr_data_q     <= wr_data_d;
      ld_ptr_q      <= ld_ptr_d;
    end
  end

  assign bus.rdfifo_rdptr    = ReloadPtr;
  assign bus.ld_rdfifo_rdptr = ld_ptr_q;
  assign bus.rd_req          = rd_req_q;
  assign bus.wr_req          = wr_req_q;
  assign bus.wr_data         = wr_data_q;
  assign bus.migrate_done    = (state_q == StDone);
  assign bus.err_o           = (state_q == StError);
  assign bus.lines_done      = lines_done_q;
endmodule
